// File: rtl/lcd_scan.sv
// rtl/lcd_scan.sv - LCD segment scanner: fetches 32 RAM nibbles per H phase and presents segments
//
// Scans one H phase per divider_1khz rising edge. Each scan reads segment-A
// columns RAM_BASE_A+0..15 then segment-B columns RAM_BASE_B+0..15, takes bit
// [scan_h] of every nibble, and commits the 32 bits to the outputs in one cycle.
// Two 9-entry nibble shift registers (W main / W prime) run independently.
//
// Optional build macro: LCD_SCAN_BLANK_EN - blanks segment outputs while lcd_enable=0.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   divider_1khz                 scan tick (rising edge starts a scan)
//   lcd_enable                   display on (used only with LCD_SCAN_BLANK_EN)
//   bs_in[3:0]                   BS latch, bit h is BS for H=h
//   ram_rd_req/ram_addr          RAM read request, held until ram_rd_ack
//   ram_rd_ack/ram_rd_data       one-cycle acknowledge with read nibble
//   w_shift_strobe/select/data   W shift pulse, 0=W main 1=W prime, nibble in
//   current_segment_a/b/bs       committed segments for output_lcd_h_index
//   current_w_prime/w_main       W shift registers, entry 0 is newest
//   output_lcd_h_index           H index of the presented segments

module lcd_scan #(
    parameter logic [6:0] RAM_BASE_A = 7'h60,
    parameter logic [6:0] RAM_BASE_B = 7'h70
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             divider_1khz,
    input  logic             lcd_enable,
    input  logic [3:0]       bs_in,
    output logic             ram_rd_req,
    output logic [6:0]       ram_addr,
    input  logic             ram_rd_ack,
    input  logic [3:0]       ram_rd_data,
    input  logic             w_shift_strobe,
    input  logic             w_shift_select,
    input  logic [3:0]       w_shift_data,
    output logic [15:0]      current_segment_a,
    output logic [15:0]      current_segment_b,
    output logic             current_segment_bs,
    output logic [8:0][3:0]  current_w_prime,
    output logic [8:0][3:0]  current_w_main,
    output logic [1:0]       output_lcd_h_index
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    logic [1:0]  state;
    logic [1:0]  scan_h;
    logic        pending;
    logic        div_q;
    logic [4:0]  read_idx;
    logic [31:0] shadow;
    logic [15:0] seg_a_q;
    logic [15:0] seg_b_q;
    logic        seg_bs_q;
    logic        tick;

    assign tick = divider_1khz & ~div_q;

    // Reads 0..15 cover segment A, 16..31 segment B; the 7-bit add wraps.
    function automatic logic [6:0] addr_of(input logic [4:0] idx);
        return idx[4] ? (RAM_BASE_B + {3'b000, idx[3:0]})
                      : (RAM_BASE_A + {3'b000, idx[3:0]});
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= ST_IDLE;
            scan_h             <= 2'd0;
            pending            <= 1'b0;
            div_q              <= 1'b0;
            read_idx           <= 5'd0;
            shadow             <= 32'd0;
            ram_rd_req         <= 1'b0;
            ram_addr           <= 7'd0;
            seg_a_q            <= 16'd0;
            seg_b_q            <= 16'd0;
            seg_bs_q           <= 1'b0;
            output_lcd_h_index <= 2'd0;
        end else begin
            div_q <= divider_1khz;
            case (state)
                ST_IDLE: begin
                    if (tick || pending) begin
                        state      <= ST_FETCH;
                        pending    <= 1'b0;
                        read_idx   <= 5'd0;
                        ram_rd_req <= 1'b1;
                        ram_addr   <= RAM_BASE_A;
                    end
                end
                ST_FETCH: begin
                    // Only one tick is remembered; re-setting an already set flag drops extras.
                    if (tick) begin
                        pending <= 1'b1;
                    end
                    if (ram_rd_req) begin
                        if (ram_rd_ack) begin
                            shadow[read_idx] <= ram_rd_data[scan_h];
                            ram_rd_req       <= 1'b0;
                            if (read_idx == 5'd31) begin
                                state <= ST_COMMIT;
                            end else begin
                                read_idx <= read_idx + 5'd1;
                            end
                        end
                    end else begin
                        // Idle gap cycle after each ack, then present the next address.
                        ram_rd_req <= 1'b1;
                        ram_addr   <= addr_of(read_idx);
                    end
                end
                ST_COMMIT: begin
                    if (tick) begin
                        pending <= 1'b1;
                    end
                    seg_a_q            <= shadow[15:0];
                    seg_b_q            <= shadow[31:16];
                    seg_bs_q           <= bs_in[scan_h];
                    output_lcd_h_index <= scan_h;
                    scan_h             <= scan_h + 2'd1;
                    state              <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            current_w_main  <= '0;
            current_w_prime <= '0;
        end else if (w_shift_strobe) begin
            if (w_shift_select) begin
                current_w_prime <= {current_w_prime[7:0], w_shift_data};
            end else begin
                current_w_main <= {current_w_main[7:0], w_shift_data};
            end
        end
    end

`ifdef LCD_SCAN_BLANK_EN
    assign current_segment_a  = lcd_enable ? seg_a_q  : 16'd0;
    assign current_segment_b  = lcd_enable ? seg_b_q  : 16'd0;
    assign current_segment_bs = lcd_enable ? seg_bs_q : 1'b0;
`else
    logic unused_lcd_enable;
    assign unused_lcd_enable  = lcd_enable;
    assign current_segment_a  = seg_a_q;
    assign current_segment_b  = seg_b_q;
    assign current_segment_bs = seg_bs_q;
`endif

endmodule

// File: tb/tb_lcd_scan.sv
// tb/tb_lcd_scan.sv - self-checking bench for lcd_scan with RAM responder and scan model

module tb_lcd_scan;

    localparam logic [6:0] BASE_A = 7'h60;
    localparam logic [6:0] BASE_B = 7'h70;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_n        = 1'b0;
    logic            divider_1khz   = 1'b0;
    logic            lcd_enable     = 1'b1;
    logic [3:0]      bs_in          = 4'd0;
    logic            ram_rd_ack     = 1'b0;
    logic [3:0]      ram_rd_data    = 4'd0;
    logic            w_shift_strobe = 1'b0;
    logic            w_shift_select = 1'b0;
    logic [3:0]      w_shift_data   = 4'd0;
    logic            ram_rd_req;
    logic [6:0]      ram_addr;
    logic [15:0]     current_segment_a;
    logic [15:0]     current_segment_b;
    logic            current_segment_bs;
    logic [8:0][3:0] current_w_prime;
    logic [8:0][3:0] current_w_main;
    logic [1:0]      output_lcd_h_index;

    lcd_scan #(.RAM_BASE_A(BASE_A), .RAM_BASE_B(BASE_B)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .divider_1khz       (divider_1khz),
        .lcd_enable         (lcd_enable),
        .bs_in              (bs_in),
        .ram_rd_req         (ram_rd_req),
        .ram_addr           (ram_addr),
        .ram_rd_ack         (ram_rd_ack),
        .ram_rd_data        (ram_rd_data),
        .w_shift_strobe     (w_shift_strobe),
        .w_shift_select     (w_shift_select),
        .w_shift_data       (w_shift_data),
        .current_segment_a  (current_segment_a),
        .current_segment_b  (current_segment_b),
        .current_segment_bs (current_segment_bs),
        .current_w_prime    (current_w_prime),
        .current_w_main     (current_w_main),
        .output_lcd_h_index (output_lcd_h_index)
    );

    int checks = 0;
    int errors = 0;

    logic [3:0] ram [128];

    // Model state: what the display must show after each completed scan.
    logic [15:0] exp_a  = 16'd0;
    logic [15:0] exp_b  = 16'd0;
    logic        exp_bs = 1'b0;
    logic [1:0]  exp_h  = 2'd0;
    int scan_count = 0;
    int scans_done = 0;
    int ack_count  = 0;
    int commit_cd  = 0;
    int wcnt       = 0;
    int ack_lat    = 0;
    logic resp_en   = 1'b1;
    logic force_ack = 1'b0;
    logic [3:0] wm [9];
    logic [3:0] wp [9];
    logic       w_pend = 1'b0;
    logic       w_sel  = 1'b0;
    logic [3:0] w_dat  = 4'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [35:0] pack9(input logic [3:0] a [9]);
        logic [35:0] r;
        r = '0;
        for (int i = 0; i < 9; i++) r[i*4 +: 4] = a[i];
        return r;
    endfunction

    // Monitor: model update, per-cycle compare, RAM responder (all on the falling edge).
    initial begin
        logic [15:0] mask;
        logic [6:0]  ad;
        int h;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                exp_a = 16'd0; exp_b = 16'd0; exp_bs = 1'b0; exp_h = 2'd0;
                scan_count = 0; scans_done = 0; ack_count = 0; commit_cd = 0; wcnt = 0;
                for (int i = 0; i < 9; i++) begin wm[i] = 4'd0; wp[i] = 4'd0; end
                w_pend = 1'b0;
                ram_rd_ack = 1'b0;
                chk("req_in_reset", 64'(ram_rd_req), 64'd0);
                chk("addr_in_reset", 64'(ram_addr), 64'd0);
            end else begin
                // The 32nd ack is consumed on the next rising edge; commit follows one edge later.
                if (commit_cd != 0) begin
                    commit_cd--;
                    if (commit_cd == 0) begin
                        h = scan_count % 4;
                        for (int k = 0; k < 16; k++) begin
                            ad = BASE_A + 7'(k);
                            exp_a[k] = ram[ad][h];
                            ad = BASE_B + 7'(k);
                            exp_b[k] = ram[ad][h];
                        end
                        exp_bs = bs_in[h];
                        exp_h  = 2'(h);
                        scan_count++;
                        scans_done++;
                    end
                end
                if (w_pend) begin
                    if (w_sel) begin
                        for (int i = 8; i > 0; i--) wp[i] = wp[i-1];
                        wp[0] = w_dat;
                    end else begin
                        for (int i = 8; i > 0; i--) wm[i] = wm[i-1];
                        wm[0] = w_dat;
                    end
                    w_pend = 1'b0;
                end
            end
`ifdef LCD_SCAN_BLANK_EN
            mask = lcd_enable ? 16'hFFFF : 16'h0000;
`else
            mask = 16'hFFFF;
`endif
            chk("seg_a", 64'(current_segment_a), 64'(exp_a & mask));
            chk("seg_b", 64'(current_segment_b), 64'(exp_b & mask));
            chk("seg_bs", 64'(current_segment_bs), 64'(exp_bs & mask[0]));
            chk("h_index", 64'(output_lcd_h_index), 64'(exp_h));
            chk("w_main", 64'(current_w_main), 64'(pack9(wm)));
            chk("w_prime", 64'(current_w_prime), 64'(pack9(wp)));
            if (reset_n) begin
                if (force_ack) begin
                    ram_rd_ack = 1'b1;
                end else if (ram_rd_ack) begin
                    ram_rd_ack = 1'b0;
                end else if (resp_en && ram_rd_req) begin
                    if (wcnt >= ack_lat) begin
                        ad = (ack_count < 16) ? BASE_A + 7'(ack_count) : BASE_B + 7'(ack_count - 16);
                        chk("read_addr", 64'(ram_addr), 64'(ad));
                        ram_rd_data = ram[ram_addr];
                        ram_rd_ack  = 1'b1;
                        wcnt = 0;
                        ack_count++;
                        if (ack_count == 32) begin
                            ack_count = 0;
                            commit_cd = 2;
                        end
                    end else begin
                        wcnt++;
                    end
                end
                if (w_shift_strobe) begin
                    w_pend = 1'b1;
                    w_sel  = w_shift_select;
                    w_dat  = w_shift_data;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
    endtask

    task automatic tick();
        cyc(1);
        divider_1khz = 1'b1;
        cyc(2);
        divider_1khz = 1'b0;
    endtask

    task automatic wait_scans(input int target, input int budget);
        int n;
        n = 0;
        while (scans_done < target && n < budget) begin
            cyc(1);
            n++;
        end
        chk("scan_timeout", 64'(scans_done >= target), 64'd1);
    endtask

    task automatic strobe(input logic sel, input logic [3:0] data);
        w_shift_select = sel;
        w_shift_data   = data;
        w_shift_strobe = 1'b1;
        cyc(1);
        w_shift_strobe = 1'b0;
    endtask

    initial begin
        logic [3:0] seq;
        int n;
        for (int i = 0; i < 128; i++) ram[i] = 4'd0;
        cyc(3);
        chk("rst_seg_a", 64'(current_segment_a), 64'd0);
        chk("rst_h", 64'(output_lcd_h_index), 64'd0);
        chk("rst_req", 64'(ram_rd_req), 64'd0);
        reset_n = 1'b1;
        cyc(2);

        // All 32 nibbles = 1, scan H0 -> every segment bit set.
        for (int i = 'h60; i < 'h80; i++) ram[i] = 4'h1;
        bs_in = 4'b0101;
        tick();
        wait_scans(1, 300);
        cyc(2);
        chk("all1_seg_a", 64'(current_segment_a), 64'hFFFF);
        chk("all1_seg_b", 64'(current_segment_b), 64'hFFFF);
        chk("all1_h", 64'(output_lcd_h_index), 64'd0);
        chk("all1_bs", 64'(current_segment_bs), 64'd1);

        // Four H phases with RAM[0x60]=A, then wrap to H0.
        do_reset();
        for (int i = 0; i < 128; i++) ram[i] = 4'd0;
        ram['h60] = 4'hA;
        ram['h75] = 4'b0100;
        bs_in = 4'b0110;
        ack_lat = 1;
        seq = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick();
            wait_scans(i + 1, 400);
            chk("hseq_a0", 64'(current_segment_a[0]), 64'(seq[i]));
            chk("hseq_h", 64'(output_lcd_h_index), 64'(i));
        end
        chk("h2_seg_b", 64'(current_segment_b), 64'h0000);
        tick();
        wait_scans(5, 400);
        chk("wrap_h", 64'(output_lcd_h_index), 64'd0);
        chk("wrap_a0", 64'(current_segment_a[0]), 64'd0);

        // Two extra ticks during FETCH: one pending, one dropped.
        do_reset();
        ack_lat = 0;
        tick();
        cyc(5);
        tick();
        cyc(5);
        tick();
        wait_scans(2, 600);
        cyc(200);
        chk("pending_scans", 64'(scans_done), 64'd2);
        chk("pending_req_idle", 64'(ram_rd_req), 64'd0);

        // W shifts, issued while a scan is running.
        do_reset();
        tick();
        strobe(1'b0, 4'd1);
        strobe(1'b0, 4'd2);
        strobe(1'b0, 4'd3);
        chk("w_main0", 64'(current_w_main[0]), 64'd3);
        chk("w_main1", 64'(current_w_main[1]), 64'd2);
        chk("w_main2", 64'(current_w_main[2]), 64'd1);
        chk("w_prime_zero", 64'(current_w_prime), 64'd0);
        for (int i = 1; i <= 10; i++) strobe(1'b1, 4'(i));
        chk("w_prime0", 64'(current_w_prime[0]), 64'hA);
        chk("w_prime8", 64'(current_w_prime[8]), 64'd2);
        chk("w_main_kept", 64'(current_w_main[0]), 64'd3);
        wait_scans(1, 300);

        // Reset in the middle of FETCH, late ack after release.
        do_reset();
        for (int i = 0; i < 128; i++) ram[i] = 4'h3;
        bs_in = 4'b0001;
        tick();
        n = 0;
        while (ack_count < 10 && n < 300) begin
            cyc(1);
            n++;
        end
        chk("abort_reach_read10", 64'(ack_count >= 10), 64'd1);
        reset_n = 1'b0;
        resp_en = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        force_ack = 1'b1;
        cyc(2);
        force_ack = 1'b0;
        chk("abort_seg_a", 64'(current_segment_a), 64'd0);
        chk("abort_req", 64'(ram_rd_req), 64'd0);
        cyc(4);
        chk("abort_req_late", 64'(ram_rd_req), 64'd0);
        chk("abort_scans", 64'(scans_done), 64'd0);
        resp_en = 1'b1;
        tick();
        chk("restart_addr", 64'(ram_addr), 64'h60);
        wait_scans(1, 300);
        cyc(2);
        chk("restart_seg_a", 64'(current_segment_a), 64'hFFFF);

        // Display enable: blanks only when the blanking option is built in.
        lcd_enable = 1'b0;
        cyc(1);
`ifdef LCD_SCAN_BLANK_EN
        chk("blank_a", 64'(current_segment_a), 64'd0);
        chk("blank_b", 64'(current_segment_b), 64'd0);
        chk("blank_bs", 64'(current_segment_bs), 64'd0);
`else
        chk("noblank_a", 64'(current_segment_a), 64'hFFFF);
`endif
        lcd_enable = 1'b1;
        cyc(1);
        chk("unblank_a", 64'(current_segment_a), 64'hFFFF);
        chk("unblank_b", 64'(current_segment_b), 64'hFFFF);
        chk("unblank_scans", 64'(scans_done), 64'd1);

        cyc(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL global_timeout actual=running required=finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lcd_scan.md
LCD_SCAN -- requirements
Module: lcd_scan

Interface
REQ-001 SHALL have parameter RAM_BASE_A, default 7'h60, RAM nibble address of segment-A column 0.
REQ-002 SHALL have parameter RAM_BASE_B, default 7'h70, RAM nibble address of segment-B column 0.
REQ-003 SHALL have ports as listed; one clock; reset is asynchronous and active-low:
- clk  in  1  system clock
- reset_n  in  1  async active-low reset
- divider_1khz  in  1  scan tick, level; rising edge used
- lcd_enable  in  1  display-on flag (see Configuration)
- bs_in  in  4  BS latch; bit h is the BS value for H=h
- ram_rd_req  out  1  RAM read request
- ram_addr  out  7  RAM nibble address
- ram_rd_ack  in  1  one-cycle read acknowledge
- ram_rd_data  in  4  RAM nibble, valid when ram_rd_ack=1
- w_shift_strobe  in  1  one-cycle W shift pulse
- w_shift_select  in  1  0=W main, 1=W prime
- w_shift_data  in  4  nibble shifted into W
- current_segment_a  out  16  segment A for output_lcd_h_index
- current_segment_b  out  16  segment B for output_lcd_h_index
- current_segment_bs  out  1  BS for output_lcd_h_index
- current_w_prime  out  4x9  W' shift register
- current_w_main  out  4x9  W shift register
- output_lcd_h_index  out  2  H index of presented segments

Function
REQ-004 SHALL detect a tick as divider_1khz=1 with previous-cycle sample 0.
REQ-005 SHALL run FSM states IDLE, FETCH, COMMIT; IDLE->FETCH on tick or pending tick; FETCH->COMMIT after 32nd ack; COMMIT->IDLE after one cycle.
REQ-006 SHALL, in FETCH, issue 32 reads in order: RAM_BASE_A+0..15, then RAM_BASE_B+0..15; 7-bit address wrap-around on overflow.
REQ-007 SHALL hold ram_rd_req=1 and ram_addr stable until ram_rd_ack; SHALL drop ram_rd_req the cycle after ack, re-asserting with next address one cycle later (min 2 cycles/read).
REQ-008 SHALL ignore ram_rd_ack when ram_rd_req=0.
REQ-009 SHALL store bit [scan_h] of read k's data into shadow bit k of segment A (k=0..15) or bit k-16 of segment B (k=16..31).
REQ-010 SHALL, in COMMIT, load current_segment_a/b from shadow, current_segment_bs from bs_in[scan_h], output_lcd_h_index from scan_h, all in the same cycle; then scan_h <= scan_h+1 mod 4 (3->0).
REQ-011 SHALL latch one pending tick if a tick arrives outside IDLE; further ticks while pending SHALL be dropped; pending is consumed on IDLE->FETCH.
REQ-012 SHALL, on w_shift_strobe, shift selected register: entry[i] <= entry[i-1] for i=8..1, entry[0] <= w_shift_data; other register unchanged; independent of FSM state.
REQ-013 SHALL give W output latency of 1 cycle from strobe.
REQ-014 SHALL never change segment outputs outside COMMIT.

Reset
REQ-015 SHALL, with reset_n=0, force: FSM IDLE, scan_h=0, pending=0, ram_rd_req=0, ram_addr=0, all segment outputs 0, output_lcd_h_index=0, both W registers all 0, edge-detect sample 0.
REQ-016 SHALL abort any in-flight FETCH on reset without commit; a late ram_rd_ack after reset release SHALL be ignored.

Configuration
REQ-017 SHALL, with LCD_SCAN_BLANK_EN defined, gate current_segment_a/b/bs to 0 whenever lcd_enable=0 (combinational, same cycle), internal registers unaffected; without it, lcd_enable SHALL be ignored.

Verification
REQ-018 Reset then one tick, RAM[0x60..0x7F]=4'h1, ack 1 cycle after req -> 32 reads, COMMIT gives segment_a=16'hFFFF, segment_b=16'hFFFF, h_index=0.
REQ-019 Four ticks, RAM[0x60]=4'hA, others 0 -> segment_a bit0 sequence over H0..H3 = 0,1,0,1; fifth scan h_index=0 (wrap).
REQ-020 Tick plus two more ticks during FETCH -> exactly two scans total (one pending, one dropped).
REQ-021 Three w_shift_strobe, select=0, data 1,2,3 -> current_w_main[0]=3,[1]=2,[2]=1, w_prime all 0.
REQ-022 reset_n low at read 10 of FETCH, ack after release -> outputs remain 0, ram_rd_req=0, next tick starts at RAM_BASE_A.
REQ-023 With LCD_SCAN_BLANK_EN, lcd_enable=0 after commit of 16'hFFFF -> segment outputs 0; lcd_enable=1 -> 16'hFFFF restored without new scan.
